// File: rtl/dmem_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one data-memory/MMIO request port; load responses steered back by an in-order source-ID FIFO.
// Latency: request path 0 cycles (combinational grant + mux), response path 0 cycles (combinational steer).
// Backpressure: mN_req_ready = grant_N & s_req_ready; loads stall while OUTST_DEPTH loads are outstanding, stores never do; responses cannot be stalled.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mN_req_*  (N = 0, 1)    requester valid/ready request channel (we, addr, wdata, wstrb, tag)
//   mN_rsp_*  (N = 0, 1)    steered load response (valid, rdata, tag), no ready
//   s_req_*                 shared downstream request channel
//   s_rsp_*                 downstream load response, returned in issue order
//   outst_cnt               number of loads issued but not yet answered
//   err_spurious_rsp        sticky flag: a response arrived with nothing outstanding

// Small generic synchronous FIFO with a combinational head output.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module dmem_rr_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// Round-robin arbiter top.
// Latency: 0 cycles request, 0 cycles response.
// Backpressure: ready only for the granted requester and only when downstream is ready; full tracking FIFO blocks loads only.
module dmem_rr_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LDTAG_W     = 4,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          m0_req_valid,
    output logic                          m0_req_ready,
    input  logic                          m0_req_we,
    input  logic [ADDR_W-1:0]             m0_req_addr,
    input  logic [DATA_W-1:0]             m0_req_wdata,
    input  logic [DATA_W/8-1:0]           m0_req_wstrb,
    input  logic [LDTAG_W-1:0]            m0_req_tag,
    output logic                          m0_rsp_valid,
    output logic [DATA_W-1:0]             m0_rsp_rdata,
    output logic [LDTAG_W-1:0]            m0_rsp_tag,

    input  logic                          m1_req_valid,
    output logic                          m1_req_ready,
    input  logic                          m1_req_we,
    input  logic [ADDR_W-1:0]             m1_req_addr,
    input  logic [DATA_W-1:0]             m1_req_wdata,
    input  logic [DATA_W/8-1:0]           m1_req_wstrb,
    input  logic [LDTAG_W-1:0]            m1_req_tag,
    output logic                          m1_rsp_valid,
    output logic [DATA_W-1:0]             m1_rsp_rdata,
    output logic [LDTAG_W-1:0]            m1_rsp_tag,

    output logic                          s_req_valid,
    input  logic                          s_req_ready,
    output logic                          s_req_we,
    output logic [ADDR_W-1:0]             s_req_addr,
    output logic [DATA_W-1:0]             s_req_wdata,
    output logic [DATA_W/8-1:0]           s_req_wstrb,
    output logic [LDTAG_W-1:0]            s_req_tag,
    input  logic                          s_rsp_valid,
    input  logic [DATA_W-1:0]             s_rsp_rdata,
    input  logic [LDTAG_W-1:0]            s_rsp_tag,

    output logic [$clog2(OUTST_DEPTH):0]  outst_cnt,
    output logic                          err_spurious_rsp
);
    localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;

    // Round-robin pointer: 0 = m0 wins a tie, 1 = m1 wins a tie.
    logic rr_ptr_q, rr_ptr_d;
    logic err_q, err_d;

    logic elig0, elig1;
    logic gnt0, gnt1;
    logic gnt_id;
    logic fire;
    logic push, pop;
    logic fifo_head;
    logic fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Full check uses the registered count: a pop this cycle does not
    // free a slot for a load pushing this cycle.
    assign elig0 = m0_req_valid & (m0_req_we | ~fifo_full);
    assign elig1 = m1_req_valid & (m1_req_we | ~fifo_full);

    assign gnt0   = elig0 & (~elig1 | ~rr_ptr_q);
    assign gnt1   = elig1 & (~elig0 |  rr_ptr_q);
    assign gnt_id = gnt1;

    // Request mux; payload follows m0 when nothing is granted, which is
    // harmless since s_req_valid is then 0.
    always_comb begin
        s_req_valid = gnt0 | gnt1;
        s_req_we    = m0_req_we;
        s_req_addr  = m0_req_addr;
        s_req_wdata = m0_req_wdata;
        s_req_wstrb = m0_req_wstrb;
        s_req_tag   = m0_req_tag;
        if (gnt1) begin
            s_req_we    = m1_req_we;
            s_req_addr  = m1_req_addr;
            s_req_wdata = m1_req_wdata;
            s_req_wstrb = m1_req_wstrb;
            s_req_tag   = m1_req_tag;
        end
    end

    assign m0_req_ready = gnt0 & s_req_ready;
    assign m1_req_ready = gnt1 & s_req_ready;

    assign fire = s_req_valid & s_req_ready;
    assign push = fire & ~s_req_we;
    // A response with nothing outstanding is dropped, not popped.
    assign pop  = s_rsp_valid & ~fifo_empty;

    dmem_rr_id_fifo #(
        .W     (1),
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (gnt_id),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Response steering: the FIFO head names the requester that issued
    // the oldest outstanding load. Data and tag fan out to both; only
    // the valid is steered.
    assign m0_rsp_valid = pop & ~fifo_head;
    assign m1_rsp_valid = pop &  fifo_head;
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign m0_rsp_tag   = s_rsp_tag;
    assign m1_rsp_tag   = s_rsp_tag;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        if (fire) begin
            rr_ptr_d = ~gnt_id;
        end
        if (s_rsp_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign outst_cnt        = fifo_count;
    assign err_spurious_rsp = err_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed self-checking bench for dmem_rr_arbiter (default parameters, OUTST_DEPTH=4).
// Latency: inputs change 1 time unit after a rising edge, outputs are checked 1 unit later.
// Backpressure: s_req_ready is driven directly by the bench.
module tb_dmem_rr_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic              m0_req_valid, m0_req_ready, m0_req_we;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [DATA_W-1:0] m0_req_wdata;
    logic [3:0]        m0_req_wstrb;
    logic [TAG_W-1:0]  m0_req_tag;
    logic              m0_rsp_valid;
    logic [DATA_W-1:0] m0_rsp_rdata;
    logic [TAG_W-1:0]  m0_rsp_tag;

    logic              m1_req_valid, m1_req_ready, m1_req_we;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [DATA_W-1:0] m1_req_wdata;
    logic [3:0]        m1_req_wstrb;
    logic [TAG_W-1:0]  m1_req_tag;
    logic              m1_rsp_valid;
    logic [DATA_W-1:0] m1_rsp_rdata;
    logic [TAG_W-1:0]  m1_rsp_tag;

    logic              s_req_valid, s_req_ready, s_req_we;
    logic [ADDR_W-1:0] s_req_addr;
    logic [DATA_W-1:0] s_req_wdata;
    logic [3:0]        s_req_wstrb;
    logic [TAG_W-1:0]  s_req_tag;
    logic              s_rsp_valid;
    logic [DATA_W-1:0] s_rsp_rdata;
    logic [TAG_W-1:0]  s_rsp_tag;

    logic [2:0]        outst_cnt;
    logic              err_spurious_rsp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_rr_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LDTAG_W     (TAG_W),
        .OUTST_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_req_valid     (m0_req_valid),
        .m0_req_ready     (m0_req_ready),
        .m0_req_we        (m0_req_we),
        .m0_req_addr      (m0_req_addr),
        .m0_req_wdata     (m0_req_wdata),
        .m0_req_wstrb     (m0_req_wstrb),
        .m0_req_tag       (m0_req_tag),
        .m0_rsp_valid     (m0_rsp_valid),
        .m0_rsp_rdata     (m0_rsp_rdata),
        .m0_rsp_tag       (m0_rsp_tag),
        .m1_req_valid     (m1_req_valid),
        .m1_req_ready     (m1_req_ready),
        .m1_req_we        (m1_req_we),
        .m1_req_addr      (m1_req_addr),
        .m1_req_wdata     (m1_req_wdata),
        .m1_req_wstrb     (m1_req_wstrb),
        .m1_req_tag       (m1_req_tag),
        .m1_rsp_valid     (m1_rsp_valid),
        .m1_rsp_rdata     (m1_rsp_rdata),
        .m1_rsp_tag       (m1_rsp_tag),
        .s_req_valid      (s_req_valid),
        .s_req_ready      (s_req_ready),
        .s_req_we         (s_req_we),
        .s_req_addr       (s_req_addr),
        .s_req_wdata      (s_req_wdata),
        .s_req_wstrb      (s_req_wstrb),
        .s_req_tag        (s_req_tag),
        .s_rsp_valid      (s_rsp_valid),
        .s_rsp_rdata      (s_rsp_rdata),
        .s_rsp_tag        (s_rsp_tag),
        .outst_cnt        (outst_cnt),
        .err_spurious_rsp (err_spurious_rsp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; new inputs are then driven 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0;
        m0_req_wstrb = '0; m0_req_tag = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0;
        m1_req_wstrb = '0; m1_req_tag = '0;
        s_rsp_valid = 0; s_rsp_rdata = '0; s_rsp_tag = '0;
    endtask

    task automatic m0_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [3:0] tg);
        m0_req_valid = 1; m0_req_we = we; m0_req_addr = addr;
        m0_req_wdata = wd; m0_req_wstrb = ws; m0_req_tag = tg;
    endtask

    task automatic m1_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [3:0] tg);
        m1_req_valid = 1; m1_req_we = we; m1_req_addr = addr;
        m1_req_wdata = wd; m1_req_wstrb = ws; m1_req_tag = tg;
    endtask

    initial begin
        rst_n = 0;
        s_req_ready = 1;
        idle_all();
        #2;
        // Reset state
        chk("rst_cnt",   64'(outst_cnt), 0);
        chk("rst_err",   64'(err_spurious_rsp), 0);
        chk("rst_rsp0",  64'(m0_rsp_valid), 0);
        chk("rst_rsp1",  64'(m1_rsp_valid), 0);
        chk("rst_sreqv", 64'(s_req_valid), 0);
        step();
        step();
        rst_n = 1;
        step();

        // Round-robin contention: both stores, grants 0,1,0,1
        m0_drive(1, 32'h10, 32'hD0D0_0000, 4'h1, 0);
        m1_drive(1, 32'h20, 32'hD1D1_1111, 4'h8, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_addr",  64'(s_req_addr), (i % 2 == 0) ? 64'h10 : 64'h20);
            chk("rr_wdata", 64'(s_req_wdata), (i % 2 == 0) ? 64'hD0D0_0000 : 64'hD1D1_1111);
            chk("rr_wstrb", 64'(s_req_wstrb), (i % 2 == 0) ? 64'h1 : 64'h8);
            chk("rr_rdy0",  64'(m0_req_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_rdy1",  64'(m1_req_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            step();
        end
        idle_all();

        // Load steering
        m0_drive(0, 32'h100, '0, '0, 4'd3);
        #1;
        chk("ld0_addr", 64'(s_req_addr), 64'h100);
        chk("ld0_tag",  64'(s_req_tag), 3);
        chk("ld0_we",   64'(s_req_we), 0);
        step();
        chk("ld_cnt1",  64'(outst_cnt), 1);
        m0_req_valid = 0;
        m1_drive(0, 32'h200, '0, '0, 4'd5);
        #1;
        chk("ld1_addr", 64'(s_req_addr), 64'h200);
        chk("ld1_rdy",  64'(m1_req_ready), 1);
        step();
        chk("ld_cnt2",  64'(outst_cnt), 2);
        m1_req_valid = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'hAAAA; s_rsp_tag = 4'd3;
        #1;
        chk("rsp0_v",   64'(m0_rsp_valid), 1);
        chk("rsp0_v1",  64'(m1_rsp_valid), 0);
        chk("rsp0_dat", 64'(m0_rsp_rdata), 64'hAAAA);
        chk("rsp0_tag", 64'(m0_rsp_tag), 3);
        step();
        s_rsp_valid = 0;
        #1;
        chk("ld_cnt3",  64'(outst_cnt), 1);
        step();
        s_rsp_valid = 1; s_rsp_rdata = 32'hBBBB; s_rsp_tag = 4'd5;
        #1;
        chk("rsp1_v",   64'(m1_rsp_valid), 1);
        chk("rsp1_v0",  64'(m0_rsp_valid), 0);
        chk("rsp1_dat", 64'(m1_rsp_rdata), 64'hBBBB);
        chk("rsp1_tag", 64'(m1_rsp_tag), 5);
        step();
        s_rsp_valid = 0;
        #1;
        chk("ld_cnt4",  64'(outst_cnt), 0);

        // FIFO full: four loads from m0
        for (int i = 0; i < 4; i++) begin
            m0_drive(0, 32'h300 + 32'(i * 4), '0, '0, 4'(i));
            #1;
            chk("full_fill_rdy", 64'(m0_req_ready), 1);
            step();
        end
        chk("full_cnt4", 64'(outst_cnt), 4);
        m0_drive(0, 32'h310, '0, '0, 4'd4);
        #1;
        chk("full_ld_rdy", 64'(m0_req_ready), 0);
        chk("full_sreqv",  64'(s_req_valid), 0);
        m1_drive(1, 32'h400, 32'h4444, 4'hF, 0);
        #1;
        chk("full_st_v",    64'(s_req_valid), 1);
        chk("full_st_we",   64'(s_req_we), 1);
        chk("full_st_addr", 64'(s_req_addr), 64'h400);
        chk("full_st_rdy1", 64'(m1_req_ready), 1);
        chk("full_st_rdy0", 64'(m0_req_ready), 0);
        step();
        m1_req_valid = 0;
        // Pop while a load waits: the load must still be refused this cycle
        s_rsp_valid = 1; s_rsp_rdata = 32'hC0; s_rsp_tag = 0;
        #1;
        chk("pp_rsp0",  64'(m0_rsp_valid), 1);
        chk("pp_rdy0",  64'(m0_req_ready), 0);
        chk("pp_sreqv", 64'(s_req_valid), 0);
        step();
        s_rsp_valid = 0;
        #1;
        chk("pp_cnt3",  64'(outst_cnt), 3);
        chk("pp_rdy0b", 64'(m0_req_ready), 1);
        step();
        m0_req_valid = 0;
        #1;
        chk("pp_cnt4b", 64'(outst_cnt), 4);
        for (int k = 1; k <= 4; k++) begin
            s_rsp_valid = 1; s_rsp_rdata = 32'(k); s_rsp_tag = 4'(k);
            #1;
            chk("drain_rsp0", 64'(m0_rsp_valid), 1);
            chk("drain_tag",  64'(m0_rsp_tag), 64'(k));
            chk("drain_rsp1", 64'(m1_rsp_valid), 0);
            step();
        end
        s_rsp_valid = 0;
        #1;
        chk("drain_cnt0", 64'(outst_cnt), 0);

        // Backpressure: last fire was m0, so m1 has priority
        m0_drive(1, 32'h500, 32'h55, 4'h3, 0);
        m1_drive(1, 32'h600, 32'h66, 4'hC, 0);
        s_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy0", 64'(m0_req_ready), 0);
            chk("bp_rdy1", 64'(m1_req_ready), 0);
            chk("bp_addr", 64'(s_req_addr), 64'h600);
            step();
        end
        s_req_ready = 1;
        #1;
        chk("bp_fire_rdy1",  64'(m1_req_ready), 1);
        chk("bp_fire_rdy0",  64'(m0_req_ready), 0);
        chk("bp_fire_wdata", 64'(s_req_wdata), 64'h66);
        chk("bp_fire_wstrb", 64'(s_req_wstrb), 64'hC);
        step();
        chk("bp_next_rdy0",  64'(m0_req_ready), 1);
        chk("bp_next_addr",  64'(s_req_addr), 64'h500);
        chk("bp_next_wstrb", 64'(s_req_wstrb), 64'h3);
        step();
        idle_all();

        // Spurious response
        s_rsp_valid = 1; s_rsp_rdata = 32'hDEAD; s_rsp_tag = 4'd7;
        #1;
        chk("sp_rsp0", 64'(m0_rsp_valid), 0);
        chk("sp_rsp1", 64'(m1_rsp_valid), 0);
        chk("sp_err_pre", 64'(err_spurious_rsp), 0);
        step();
        s_rsp_valid = 0;
        #1;
        chk("sp_err", 64'(err_spurious_rsp), 1);
        chk("sp_cnt", 64'(outst_cnt), 0);
        step();
        chk("sp_err_sticky", 64'(err_spurious_rsp), 1);

        // Two loads outstanding, then reset mid-stream
        m0_drive(0, 32'h700, '0, '0, 4'd1);
        step();
        step();
        chk("rs_cnt2", 64'(outst_cnt), 2);
        // Last fire was m0, so m1 wins a tie before reset
        m0_drive(1, 32'h500, 32'h55, 4'h3, 0);
        m1_drive(1, 32'h600, 32'h66, 4'hC, 0);
        #1;
        chk("rs_pre_addr", 64'(s_req_addr), 64'h600);
        rst_n = 0;
        #1;
        chk("rs_cnt0",  64'(outst_cnt), 0);
        chk("rs_err0",  64'(err_spurious_rsp), 0);
        chk("rs_addr",  64'(s_req_addr), 64'h500);
        chk("rs_rdy0",  64'(m0_req_ready), 1);
        step();
        idle_all();
        rst_n = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single data-memory/MMIO request port in front of the mmio interconnect.
- Requester 0 is the CPU LSU; requester 1 is a DMA/debug master.
- Stores are forwarded; loads are forwarded and their responses are steered back to the issuing requester.
- An in-order source-ID FIFO does the steering, since the downstream fabric returns load responses in issue order.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, read/write data width.
- LDTAG_W, 4, load tag width; carried through unchanged.
- OUTST_DEPTH, 4, maximum outstanding loads (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_req_valid  in  1  request valid (N = 0, 1 for every mN_ line)
- mN_req_ready  out  1  request accepted this cycle
- mN_req_we  in  1  1 = store, 0 = load
- mN_req_addr  in  ADDR_W  byte address
- mN_req_wdata  in  DATA_W  store data
- mN_req_wstrb  in  DATA_W/8  store byte enables
- mN_req_tag  in  LDTAG_W  load tag
- mN_rsp_valid  out  1  load response valid
- mN_rsp_rdata  out  DATA_W  load data
- mN_rsp_tag  out  LDTAG_W  load tag echoed
- s_req_valid/we/addr/wdata/wstrb/tag  out  as above  downstream request
- s_req_ready  in  1  downstream accepts
- s_rsp_valid  in  1  downstream load response
- s_rsp_rdata  in  DATA_W  response data
- s_rsp_tag  in  LDTAG_W  response tag
- outst_cnt  out  $clog2(OUTST_DEPTH)+1  outstanding loads
- err_spurious_rsp  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, meaning m0 has priority.
  - FIFO empty, outst_cnt=0, err_spurious_rsp=0.
  - All mN_rsp_valid=0.
  - s_req_valid follows the combinational rule below; with no requests it is 0.
- Eligibility: requester N is eligible iff mN_req_valid=1 AND (mN_req_we=1 OR outst_cnt<OUTST_DEPTH).
  - A full FIFO blocks loads only.
  - A pop in the same cycle does not free a slot for a push; the check uses the registered count.
- Grant (combinational, same cycle):
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one rr_ptr points to.
  - If neither is eligible, there is no grant.
- Request path:
  - s_req_* are muxed from the granted requester.
  - s_req_valid=1 iff a grant exists.
  - mN_req_ready = grant_N & s_req_ready.
  - A non-granted or ineligible requester sees ready=0.
- Grant stability: grant is recomputed every cycle with no lock.
  - A requester must hold valid and payload stable until ready (standard valid/ready).
  - The arbiter may switch grant between cycles while s_req_ready=0. Downstream must tolerate this; the interconnect samples only on valid&ready.
- Fire = s_req_valid & s_req_ready. On fire:
  - rr_ptr <= ~granted_id, so the other requester gets priority next. rr_ptr updates only on fire.
  - If the fired request is a load, push granted_id to the FIFO.
- Response path:
  - On s_rsp_valid, pop the FIFO head id H.
  - Drive mH_rsp_valid=1, mH_rsp_rdata=s_rsp_rdata, mH_rsp_tag=s_rsp_tag in the same cycle, combinationally, with zero added latency.
  - The other requester's rsp_valid stays 0.
  - Responses have no backpressure.
- Simultaneous push and pop: both occur and outst_cnt is unchanged. Pointers wrap modulo OUTST_DEPTH.
- Spurious response (s_rsp_valid with FIFO empty):
  - No mN_rsp_valid is asserted and the FIFO is unchanged.
  - err_spurious_rsp <= 1 and stays set until reset.
- outst_cnt: increments on load fire, decrements on pop, and never exceeds OUTST_DEPTH.
- Reset mid-operation: all in-flight tracking is discarded. The downstream is reset by the same rst_n, so no stale responses are expected; any that arrive set err_spurious_rsp.
- Latency: request 0 cycles (combinational pass-through); response 0 cycles.

Test Plan:
- Round-robin contention: m0 and m1 both issue stores continuously, s_req_ready=1. s_req grants go 0,1,0,1… starting with m0 after reset; each requester gets ready on alternate cycles.
- Load steering: m0 loads addr 0x100 with tag 3, then m1 loads addr 0x200 with tag 5; downstream returns 0xAAAA/tag3 then 0xBBBB/tag5 two cycles later. m0_rsp_valid pulses with 0xAAAA/tag3, then m1_rsp_valid with 0xBBBB/tag5; outst_cnt goes 1,2,1,0.
- FIFO full (OUTST_DEPTH=4): four loads issued with no responses. outst_cnt=4, a fifth load sees ready=0, and a store from the other requester is still granted. Once a response pops, the next cycle accepts the load.
- Push/pop same cycle at cnt=4: a response arrives while a load is pending. The load is not accepted that cycle, cnt drops to 3, and the load fires the following cycle.
- Backpressure: s_req_ready=0 for 3 cycles with both valid. No fire, rr_ptr unchanged, and both ready=0; on ready=1 the prioritized requester fires.
- Spurious response and reset: s_rsp_valid with FIFO empty gives no mN_rsp_valid and err_spurious_rsp=1. Asserting rst_n=0 mid-stream with 2 loads outstanding gives outst_cnt=0, err=0, rr_ptr=0 immediately.
